hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the consecutive mem_busy cycles after which mem_timeout sets (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port id_rs1, id_rs2  input  5 each  ID-stage source register indices.
REQ-005 SHALL have port id_rs1_used, id_rs2_used  input  1 each  ID instruction reads rs1 / rs2.
REQ-006 SHALL have port ex_rd  input  5  EX-stage destination register.
REQ-007 SHALL have port ex_is_load  input  1  EX instruction is a load.
REQ-008 SHALL have port ex_redirect  input  1  branch taken or jump resolved in EX.
REQ-009 SHALL have port mem_busy  input  1  data memory not ready; whole pipeline must hold.
REQ-010 SHALL have port data_hazard  output  1  PC hold request, to the PC register.
REQ-011 SHALL have port control_hazard  output  1  PC redirect request, to the PC register.
REQ-012 SHALL have ports if_id_stall, if_id_flush, id_ex_flush, pipe_freeze  output  1 each  pipeline register controls.
REQ-013 SHALL have port state  output  2  current FSM state: RUN=0, LD_STALL=1, REDIRECT=2, MEM_WAIT=3.
REQ-014 SHALL have port mem_timeout  output  1  sticky watchdog flag.
REQ-015 SHALL have ports stall_cycles, flush_events  output  32 each  performance counters.

Function
REQ-016 SHALL compute load_use = ex_is_load && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
REQ-017 SHALL drive all non-counter outputs combinationally from current state and inputs (zero-cycle latency); only state, the watchdog count, mem_timeout and the counters are registered.
REQ-018 SHALL apply priority mem_busy > ex_redirect > load_use in every state.
REQ-019 mem_busy=1, any state: pipe_freeze=1, data_hazard=1, if_id_stall=1, all flushes=0, control_hazard=0; next state MEM_WAIT.
REQ-020 MEM_WAIT with mem_busy=0: evaluate ex_redirect/load_use exactly as in RUN in the same cycle; exit per REQ-021..023.
REQ-021 ex_redirect=1 (mem_busy=0), RUN/LD_STALL/MEM_WAIT: control_hazard=1, if_id_flush=1, id_ex_flush=1, data_hazard=0; next state REDIRECT.
REQ-022 load_use=1 (no higher-priority event), RUN/MEM_WAIT: data_hazard=1, if_id_stall=1, id_ex_flush=1; next state LD_STALL.
REQ-023 LD_STALL: load_use is ignored (no back-to-back stall); with no higher-priority event, outputs all 0; next state RUN.
REQ-024 REDIRECT: load_use is masked, since ID holds a flushed bubble; ex_redirect is still honoured per REQ-021; otherwise outputs all 0; next state RUN.
REQ-025 SHALL count consecutive mem_busy cycles in a 16-bit saturating counter, cleared when mem_busy=0.
REQ-026 SHALL set mem_timeout on the cycle the count reaches MEM_TIMEOUT; mem_timeout holds until rst.
REQ-027 data_hazard and control_hazard SHALL never both be 1 in the same cycle.

Reset
REQ-028 rst=1 at a clock edge: state=RUN, watchdog count=0, mem_timeout=0, stall_cycles=0, flush_events=0.
REQ-029 rst SHALL override every input, including mid-MEM_WAIT and mid-LD_STALL; rst is not sampled asynchronously.
REQ-030 While rst=1, combinational outputs SHALL still follow the RUN-state equations.

Configuration
REQ-031 Macro PERF_CNT_EN defined: stall_cycles increments (wrapping at 2^32) on each cycle data_hazard=1; flush_events increments (wrapping) on each cycle control_hazard=1.
REQ-032 Macro PERF_CNT_EN undefined: the counter logic is omitted and stall_cycles, flush_events are tied to 0; all ports remain present.

Verification
REQ-033 Load x5 in EX, ID uses rs1=5 -> one cycle of data_hazard=1, if_id_stall=1, id_ex_flush=1, state RUN->LD_STALL->RUN; stall_cycles +1.
REQ-034 ex_rd=0 with ex_is_load=1 and id_rs1=0 -> no stall.
REQ-035 ex_redirect=1 while load_use=1 -> control_hazard=1, data_hazard=0, state REDIRECT; next cycle load_use=1 produces no stall.
REQ-036 mem_busy=1 for 3 cycles together with ex_redirect=1 -> pipe_freeze=1 and control_hazard=0 for 3 cycles, then control_hazard=1 on the first non-busy cycle.
REQ-037 MEM_TIMEOUT=4, mem_busy held for 6 cycles -> mem_timeout rises after the 4th busy cycle and stays 1 after mem_busy drops, until rst.
REQ-038 rst asserted in LD_STALL with mem_busy=1 -> next state RUN, counters 0, mem_timeout 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect, memory freeze and a busy watchdog.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  output logic        data_hazard,
  output logic        control_hazard,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pipe_freeze,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d, cur_state;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic        load_use;
  logic        load_use_allowed;

  // While reset is held the outputs behave as if the FSM were already in RUN.
  assign cur_state = rst ? RUN : state_q;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  assign load_use_allowed = (cur_state == RUN) || (cur_state == MEM_WAIT);

  always_comb begin
    state_d        = RUN;
    data_hazard    = 1'b0;
    control_hazard = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    pipe_freeze    = 1'b0;
    if (mem_busy) begin
      pipe_freeze = 1'b1;
      data_hazard = 1'b1;
      if_id_stall = 1'b1;
      state_d     = MEM_WAIT;
    end else if (ex_redirect) begin
      control_hazard = 1'b1;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      state_d        = REDIRECT;
    end else if (load_use && load_use_allowed) begin
      data_hazard = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = LD_STALL;
    end
  end

  // Watchdog counts consecutive busy cycles and saturates rather than wrapping.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!mem_busy) begin
      wd_cnt_d = 16'd0;
    end else if (wd_cnt_q != 16'hFFFF) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
    mem_timeout_d = mem_timeout_q || (mem_busy && (wd_cnt_d == TIMEOUT_LIM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wd_cnt_q      <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_cnt_q      <= wd_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, data_hazard};
    flush_events_d = flush_events_q + {31'd0, control_hazard};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MEM_TIMEOUT=4); counter expectations follow PERF_CNT_EN.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, mem_busy;
  logic        data_hazard, control_hazard, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_events;

  int vectors = 0;
  int miscompares = 0;

`ifdef PERF_CNT_EN
  localparam int PC = 1;
`else
  localparam int PC = 0;
`endif

  // {data_hazard, control_hazard, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_MEM  = 6'b101001;
  localparam logic [5:0] O_RED  = 6'b010110;
  localparam logic [5:0] O_LDS  = 6'b101010;

  wire [5:0] outs = {data_hazard, control_hazard, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze};

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .data_hazard(data_hazard), .control_hazard(control_hazard),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze),
    .state(state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_load_use_rs1(input logic [4:0] r);
    ex_is_load = 1'b1; ex_rd = r; id_rs1 = r; id_rs1_used = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    ex_redirect = 1'b1;
    #1;
    vectors++;
    if (outs !== O_RED) begin miscompares++; $display("FAIL rst_comb_redirect outs=%b want %b", outs, O_RED); end
    tick(); tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL rst_state state=%0d want 0", state); end
    vectors++;
    if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got %b want 0", mem_timeout); end
    vectors++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      miscompares++; $display("FAIL rst_counters stall=%0d flush=%0d want 0 0", stall_cycles, flush_events);
    end
    clear_inputs();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_load_use;
    set_load_use_rs1(5'd5);
    #1;
    vectors++;
    if (outs !== O_LDS) begin miscompares++; $display("FAIL lu_outs outs=%b want %b", outs, O_LDS); end
    tick();
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL lu_state state=%0d want 1", state); end
    #1;
    vectors++;
    if (outs !== O_NONE) begin miscompares++; $display("FAIL lu_no_b2b outs=%b want %b", outs, O_NONE); end
    tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL lu_back_run state=%0d want 0", state); end
    vectors++;
    if (stall_cycles !== 32'(PC * 1)) begin miscompares++; $display("FAIL lu_stall_cnt got %0d want %0d", stall_cycles, PC * 1); end
    clear_inputs();
    $display("test_load_use done");
  endtask

  task automatic test_rd_zero;
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1;
    vectors++;
    if (outs !== O_NONE) begin miscompares++; $display("FAIL rd0_outs outs=%b want %b", outs, O_NONE); end
    tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL rd0_state state=%0d want 0", state); end
    ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b0; id_rs1 = 5'd3;
    #1;
    vectors++;
    if (outs !== O_NONE) begin miscompares++; $display("FAIL rs2_unused outs=%b want %b", outs, O_NONE); end
    id_rs2_used = 1'b1;
    #1;
    vectors++;
    if (outs !== O_LDS) begin miscompares++; $display("FAIL rs2_used outs=%b want %b", outs, O_LDS); end
    tick();
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL rs2_state state=%0d want 1", state); end
    clear_inputs();
    tick();
    vectors++;
    if (stall_cycles !== 32'(PC * 2)) begin miscompares++; $display("FAIL rs2_stall_cnt got %0d want %0d", stall_cycles, PC * 2); end
    $display("test_rd_zero done");
  endtask

  task automatic test_redirect_masks;
    set_load_use_rs1(5'd5);
    ex_redirect = 1'b1;
    #1;
    vectors++;
    if (outs !== O_RED) begin miscompares++; $display("FAIL red_prio outs=%b want %b", outs, O_RED); end
    tick();
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL red_state state=%0d want 2", state); end
    ex_redirect = 1'b0;
    #1;
    vectors++;
    if (outs !== O_NONE) begin miscompares++; $display("FAIL red_mask_lu outs=%b want %b", outs, O_NONE); end
    tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL red_back_run state=%0d want 0", state); end
    clear_inputs();
    $display("test_redirect_masks done");
  endtask

  task automatic test_back_to_back;
    ex_redirect = 1'b1;
    tick();
    #1;
    vectors++;
    if (outs !== O_RED) begin miscompares++; $display("FAIL b2b_red outs=%b want %b", outs, O_RED); end
    tick();
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL b2b_state state=%0d want 2", state); end
    clear_inputs();
    tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL b2b_run state=%0d want 0", state); end
    vectors++;
    if (flush_events !== 32'(PC * 3)) begin miscompares++; $display("FAIL b2b_flush_cnt got %0d want %0d", flush_events, PC * 3); end
    $display("test_back_to_back done");
  endtask

  task automatic test_mem_busy_redirect;
    mem_busy = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (outs !== O_MEM) begin miscompares++; $display("FAIL mb_outs cyc=%0d outs=%b want %b", i, outs, O_MEM); end
      tick();
      vectors++;
      if (state !== 2'd3) begin miscompares++; $display("FAIL mb_state cyc=%0d state=%0d want 3", i, state); end
    end
    mem_busy = 1'b0;
    #1;
    vectors++;
    if (outs !== O_RED) begin miscompares++; $display("FAIL mb_exit_red outs=%b want %b", outs, O_RED); end
    tick();
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL mb_exit_state state=%0d want 2", state); end
    clear_inputs();
    mem_busy = 1'b1;
    set_load_use_rs1(5'd9);
    tick();
    mem_busy = 1'b0;
    #1;
    vectors++;
    if (outs !== O_LDS) begin miscompares++; $display("FAIL mw_lu outs=%b want %b", outs, O_LDS); end
    tick();
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL mw_lu_state state=%0d want 1", state); end
    clear_inputs();
    tick();
    vectors++;
    if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL mb_no_timeout got %b want 0", mem_timeout); end
    vectors++;
    if (stall_cycles !== 32'(PC * 7) || flush_events !== 32'(PC * 4)) begin
      miscompares++; $display("FAIL mb_counters stall=%0d flush=%0d want %0d %0d", stall_cycles, flush_events, PC * 7, PC * 4);
    end
    $display("test_mem_busy_redirect done");
  endtask

  task automatic test_timeout;
    mem_busy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      vectors++;
      if (mem_timeout !== (k >= 4)) begin miscompares++; $display("FAIL to_busy k=%0d got %b want %b", k, mem_timeout, (k >= 4)); end
    end
    mem_busy = 1'b0;
    tick(); tick();
    vectors++;
    if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky got %b want 1", mem_timeout); end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL to_state state=%0d want 0", state); end
    vectors++;
    if (stall_cycles !== 32'(PC * 13)) begin miscompares++; $display("FAIL to_stall_cnt got %0d want %0d", stall_cycles, PC * 13); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_override;
    set_load_use_rs1(5'd5);
    tick();
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL ro_pre state=%0d want 1", state); end
    rst = 1'b1; mem_busy = 1'b1;
    #1;
    vectors++;
    if (outs !== O_MEM) begin miscompares++; $display("FAIL ro_comb outs=%b want %b", outs, O_MEM); end
    tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL ro_state state=%0d want 0", state); end
    vectors++;
    if (mem_timeout !== 1'b0 || stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      miscompares++; $display("FAIL ro_clear to=%b stall=%0d flush=%0d want 0 0 0", mem_timeout, stall_cycles, flush_events);
    end
    rst = 1'b0;
    clear_inputs();
    mem_busy = 1'b1;
    tick();
    vectors++;
    if (state !== 2'd3) begin miscompares++; $display("FAIL ro_memwait state=%0d want 3", state); end
    rst = 1'b1;
    tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL ro_memwait_rst state=%0d want 0", state); end
    rst = 1'b0;
    clear_inputs();
    $display("test_reset_override done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_redirect_masks();
    test_back_to_back();
    test_mem_busy_redirect();
    test_timeout();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
